// File: rtl/tree_adder_pkg.sv
// rtl/tree_adder_pkg.sv - shared state encoding and sizing helpers for the wide tree-adder sequencer
package tree_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit 0 of the adder is the carry-in slot, so each chunk is one bit narrower.
    function automatic int chunk_w(input int adder_size);
        return adder_size - 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/brent_kung.sv
// rtl/brent_kung.sv - combinational Brent-Kung adder: ripple groups of GROUP_SIZE bits joined by a prefix tree
module brent_kung #(
    parameter int ADDER_SIZE = 16,
    parameter int GROUP_SIZE = 4,
    parameter int LEV        = 3
) (
    input  logic [ADDER_SIZE-1:1] a,
    input  logic [ADDER_SIZE-1:1] b,
    input  logic                  cin,
    output logic [ADDER_SIZE-1:1] sum,
    output logic                  cout
);

    localparam int NG = (ADDER_SIZE + GROUP_SIZE - 1) / GROUP_SIZE;

    // LEV must cover clog2(NG) up-sweep levels; extra levels fall outside the group range and do nothing.
    always_comb begin
        logic [ADDER_SIZE-1:0] g;
        logic [ADDER_SIZE-1:0] p;
        logic [ADDER_SIZE-1:1] c;
        logic [NG-1:0]         gg;
        logic [NG-1:0]         pp;
        logic                  cc;

        g = {a & b, cin};
        p = {a ^ b, 1'b0};

        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            pp[j] = 1'b1;
            for (int k = 0; k < GROUP_SIZE; k++) begin
                if (j * GROUP_SIZE + k < ADDER_SIZE) begin
                    gg[j] = g[j*GROUP_SIZE+k] | (p[j*GROUP_SIZE+k] & gg[j]);
                    pp[j] = pp[j] & p[j*GROUP_SIZE+k];
                end
            end
        end

        for (int l = 0; l < LEV; l++) begin
            for (int i = (2 << l) - 1; i < NG; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                pp[i] = pp[i] & pp[i-(1<<l)];
            end
        end

        for (int l = LEV - 1; l >= 0; l--) begin
            for (int i = (3 << l) - 1; i < NG; i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                pp[i] = pp[i] & pp[i-(1<<l)];
            end
        end

        // Carry out of bit 0 is cin itself; group boundaries reload from the prefix tree.
        cc = cin;
        for (int k = 1; k < ADDER_SIZE; k++) begin
            if (k % GROUP_SIZE == 0) cc = gg[k/GROUP_SIZE-1];
            c[k] = cc;
            cc   = g[k] | (p[k] & cc);
        end

        sum  = p[ADDER_SIZE-1:1] ^ c;
        cout = gg[NG-1];
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle wide adder over a Brent-Kung chunk adder; WIDE_ADD_SUB_EN adds subtract mode
module wide_add_sequencer
    import tree_adder_pkg::*;
#(
    parameter  int ADDER_SIZE = 16,
    parameter  int GROUP_SIZE = 4,
    parameter  int LEV        = 3,
    parameter  int NUM_WORDS  = 4,
    localparam int W          = chunk_w(ADDER_SIZE),
    localparam int N          = NUM_WORDS * W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout
);

    localparam int              IW       = (clog2(NUM_WORDS) < 1) ? 1 : clog2(NUM_WORDS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_WORDS - 1);

    logic [1:0]    state;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  result;
    logic [N-1:0]  next_result;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  chunk_a;
    logic [W-1:0]  chunk_b;
    logic [W-1:0]  chunk_sum;
    logic          chunk_cout;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        chunk_a                  = op_a[idx*W +: W];
        chunk_b                  = op_b[idx*W +: W];
        next_result              = result;
        next_result[idx*W +: W]  = chunk_sum;
    end

    brent_kung #(
        .ADDER_SIZE (ADDER_SIZE),
        .GROUP_SIZE (GROUP_SIZE),
        .LEV        (LEV)
    ) u_bk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
`ifdef WIDE_ADD_SUB_EN
                        // Subtract as a + ~b + 1, so the final carry reads as "no borrow".
                        op_b  <= in_sub ? ~in_b : in_b;
                        carry <= in_sub | in_cin;
`else
                        op_b  <= in_b;
                        carry <= in_cin;
`endif
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result <= next_result;
                    carry  <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        out_sum  <= next_result;
                        out_cout <= chunk_cout;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
